// File: rtl/cpu_test_sequencer.sv
// Run-and-check controller: resets the CPU, runs it for a bounded budget or until halt,
// then reads back a table of expected register values and reports a verdict.
module cpu_test_sequencer #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_CHECKS   = 8,
  parameter int RESET_CYCLES = 2,
  parameter int CYCLE_BUDGET = 20,
  parameter int HALT_CYCLES  = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(CYCLE_BUDGET + 1),
  localparam int FW = $clog2(NUM_CHECKS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_CHECKS-1:0]      check_en,
  input  logic [NUM_CHECKS*AW-1:0]   check_addr,
  input  logic [NUM_CHECKS*XLEN-1:0] check_data,
  input  logic [XLEN-1:0]            pc,
  output logic                       cpu_rst,
  output logic                       cpu_run,
  output logic [AW-1:0]              rf_raddr,
  input  logic [XLEN-1:0]            rf_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       halted,
  output logic [NUM_CHECKS-1:0]      fail_mask,
  output logic [FW-1:0]              fail_count,
  output logic [CW-1:0]              cycles_run
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SW = (HALT_CYCLES > 0) ? $clog2(HALT_CYCLES + 1) : 1;
  localparam bit HALT_EN = (HALT_CYCLES > 0);
  localparam logic [CW-1:0] BUDGET_C   = CW'(CYCLE_BUDGET);
  localparam logic [SW-1:0] HALT_C     = SW'(HALT_CYCLES);
  localparam logic [FW-1:0] LAST_C     = FW'(NUM_CHECKS);
  localparam logic [RW-1:0] RST_LOAD_C = RW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]         cycles_run_q, cycles_run_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic [XLEN-1:0]       pc_prev_q, pc_prev_d;
  logic [FW-1:0]         chk_q, chk_d;
  logic [NUM_CHECKS-1:0] fail_mask_q, fail_mask_d;
  logic [FW-1:0]         fail_count_q, fail_count_d;
  logic                  pass_q, pass_d;
  logic                  halted_q, halted_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  cpu_run_q, cpu_run_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         rf_raddr_q, rf_raddr_d;
  logic [NUM_CHECKS-1:0] cmp_hit;
  logic                  halt_hit;
  logic                  budget_hit;

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cycles_run_d = cycles_run_q;
    stable_d     = stable_q;
    pc_prev_d    = pc_prev_q;
    chk_d        = chk_q;
    fail_mask_d  = fail_mask_q;
    fail_count_d = fail_count_q;
    pass_d       = pass_q;
    halted_d     = halted_q;
    cmp_hit      = {NUM_CHECKS{1'b0}};
    halt_hit     = 1'b0;
    budget_hit   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RESET;
          rst_cnt_d    = RST_LOAD_C;
          cycles_run_d = {CW{1'b0}};
          fail_mask_d  = {NUM_CHECKS{1'b0}};
          fail_count_d = {FW{1'b0}};
          halted_d     = 1'b0;
          pass_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == {RW{1'b0}}) begin
          state_d  = S_RUN;
          stable_d = {SW{1'b0}};
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        pc_prev_d = pc;
        if (cycles_run_q == BUDGET_C) begin
          cycles_run_d = cycles_run_q;
        end else begin
          cycles_run_d = cycles_run_q + 1'b1;
        end
        // The first RUN cycle has no previous PC, so it always breaks the stable streak
        if (cycles_run_q == {CW{1'b0}}) begin
          stable_d = {SW{1'b0}};
        end else if (pc == pc_prev_q) begin
          stable_d = stable_q + 1'b1;
        end else begin
          stable_d = {SW{1'b0}};
        end
        halt_hit   = HALT_EN && (stable_d == HALT_C);
        budget_hit = (cycles_run_d == BUDGET_C);
        if (halt_hit || budget_hit) begin
          state_d  = S_CHECK;
          halted_d = halt_hit;
          chk_d    = {FW{1'b0}};
        end else begin
          state_d = S_RUN;
        end
      end
      S_CHECK: begin
        // Read data arriving in cycle k+1 belongs to the entry addressed in cycle k
        for (int i = 0; i < NUM_CHECKS; i++) begin
          cmp_hit[i] = (chk_q == FW'(i + 1)) && check_en[i] &&
                       (rf_rdata != check_data[i*XLEN +: XLEN]);
        end
        fail_mask_d = fail_mask_q | cmp_hit;
        if (|cmp_hit) begin
          fail_count_d = fail_count_q + 1'b1;
        end else begin
          fail_count_d = fail_count_q;
        end
        chk_d = chk_q + 1'b1;
        if (chk_q == LAST_C) begin
          state_d = S_DONE;
          pass_d  = (fail_count_d == {FW{1'b0}});
        end else begin
          state_d = S_CHECK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rf_raddr_d = {AW{1'b0}};
    for (int i = 0; i < NUM_CHECKS; i++) begin
      rf_raddr_d = rf_raddr_d |
                   ({AW{(state_d == S_CHECK) && (chk_d == FW'(i))}} & check_addr[i*AW +: AW]);
    end

    cpu_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
    cpu_run_d = (state_d == S_RUN);
    busy_d    = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_CHECK);
    done_d    = (state_d == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= {RW{1'b0}};
      cycles_run_q <= {CW{1'b0}};
      stable_q     <= {SW{1'b0}};
      pc_prev_q    <= {XLEN{1'b0}};
      chk_q        <= {FW{1'b0}};
      fail_mask_q  <= {NUM_CHECKS{1'b0}};
      fail_count_q <= {FW{1'b0}};
      pass_q       <= 1'b0;
      halted_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_raddr_q   <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycles_run_q <= cycles_run_d;
      stable_q     <= stable_d;
      pc_prev_q    <= pc_prev_d;
      chk_q        <= chk_d;
      fail_mask_q  <= fail_mask_d;
      fail_count_q <= fail_count_d;
      pass_q       <= pass_d;
      halted_q     <= halted_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_run_q    <= cpu_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rf_raddr_q   <= rf_raddr_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign cpu_run    = cpu_run_q;
  assign rf_raddr   = rf_raddr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign halted     = halted_q;
  assign fail_mask  = fail_mask_q;
  assign fail_count = fail_count_q;
  assign cycles_run = cycles_run_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: a tiny CPU/register-file model plus directed and random
// tests, with expectations derived from the run/halt/check rules.
module tb_cpu_test_sequencer;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NC   = 8;
  localparam int RC   = 2;
  localparam int CB   = 20;
  localparam int HC   = 4;
  localparam int AW   = $clog2(NR);
  localparam int CW   = $clog2(CB + 1);
  localparam int FW   = $clog2(NC + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [NC-1:0]        check_en;
  logic [NC*AW-1:0]     check_addr;
  logic [NC*XLEN-1:0]   check_data;
  logic [XLEN-1:0]      pc;
  logic                 cpu_rst;
  logic                 cpu_run;
  logic [AW-1:0]        rf_raddr;
  logic [XLEN-1:0]      rf_rdata;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 halted;
  logic [NC-1:0]        fail_mask;
  logic [FW-1:0]        fail_count;
  logic [CW-1:0]        cycles_run;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] regs [NR];
  logic [AW-1:0]   t_addr [NC];
  logic [XLEN-1:0] t_data [NC];
  bit              t_en [NC];
  int              run_idx;
  int              freeze;

  cpu_test_sequencer #(
    .XLEN(XLEN), .NUM_REGS(NR), .NUM_CHECKS(NC),
    .RESET_CYCLES(RC), .CYCLE_BUDGET(CB), .HALT_CYCLES(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .check_en(check_en), .check_addr(check_addr), .check_data(check_data),
    .pc(pc), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .pass(pass), .halted(halted),
    .fail_mask(fail_mask), .fail_count(fail_count), .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  // CPU model: registered register-file read port and a run-cycle counter driving pc
  always @(posedge clk) rf_rdata <= regs[rf_raddr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       run_idx <= 0;
    else if (cpu_rst) run_idx <= 0;
    else if (cpu_run) run_idx <= run_idx + 1;
  end

  // pc advances every run cycle until the freeze cycle (1-based), then parks at 0x20
  always_comb begin
    if (freeze != 0 && run_idx + 1 >= freeze) pc = 32'h0000_0020;
    else                                      pc = 32'h0000_0100 + 32'(4 * run_idx);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_table();
    for (int i = 0; i < NC; i++) begin
      check_addr[i*AW +: AW]     = t_addr[i];
      check_data[i*XLEN +: XLEN] = t_data[i];
      check_en[i]                = t_en[i];
    end
  endtask

  task automatic random_table();
    for (int r = 1; r < NR; r++) regs[r] = $urandom;
    regs[0] = 32'h0;
    for (int i = 0; i < NC; i++) begin
      t_addr[i] = AW'($urandom_range(0, NR - 1));
      t_en[i]   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) t_data[i] = regs[t_addr[i]] ^ (32'h1 << $urandom_range(0, 31));
      else                           t_data[i] = regs[t_addr[i]];
    end
  endtask

  // One full test from start to DONE; disturb pulses start during RUN and CHECK
  task automatic run_test(input string name, input bit disturb);
    logic [NC-1:0] e_mask;
    int e_cnt, e_run, n_rst, n_run, n_chk;
    bit e_halt, fin;

    e_mask = '0;
    e_cnt  = 0;
    for (int i = 0; i < NC; i++) begin
      if (t_en[i] && regs[t_addr[i]] !== t_data[i]) begin
        e_mask[i] = 1'b1;
        e_cnt++;
      end
    end
    e_halt = (HC > 0) && (freeze != 0) && (freeze + HC <= CB);
    e_run  = e_halt ? freeze + HC : CB;
    pack_table();

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, ":clr_mask"}, 32'(fail_mask), 32'h0);
    chk({name, ":clr_cycles"}, 32'(cycles_run), 32'h0);
    chk({name, ":busy_on"}, 32'(busy), 32'h1);

    n_rst = 0; n_run = 0; n_chk = 0; fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      start = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else if (busy && cpu_rst) begin
        n_rst++;
      end else if (cpu_run) begin
        n_run++;
        if (disturb && n_run == 5) start = 1'b1;
      end else if (busy) begin
        if (n_chk < NC) chk({name, ":raddr"}, 32'(rf_raddr), 32'(t_addr[n_chk]));
        if (disturb && n_chk == 3) start = 1'b1;
        n_chk++;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;

    chk({name, ":timeout"}, 32'(fin), 32'h1);
    chk({name, ":rst_len"}, 32'(n_rst), 32'(RC));
    chk({name, ":run_len"}, 32'(n_run), 32'(e_run));
    chk({name, ":chk_len"}, 32'(n_chk), 32'(NC + 1));
    chk({name, ":pass"}, 32'(pass), 32'(e_cnt == 0));
    chk({name, ":mask"}, 32'(fail_mask), 32'(e_mask));
    chk({name, ":count"}, 32'(fail_count), 32'(e_cnt));
    chk({name, ":cycles"}, 32'(cycles_run), 32'(e_run));
    chk({name, ":halted"}, 32'(halted), 32'(e_halt));
    chk({name, ":done_raddr"}, 32'(rf_raddr), 32'h0);
    chk({name, ":done_idle"}, {29'h0, busy, cpu_rst, cpu_run}, 32'h0);
  endtask

  initial begin
    int n_run;
    rst_n = 1'b0;
    start = 1'b0;
    freeze = 0;
    for (int r = 0; r < NR; r++) regs[r] = 32'h0;
    for (int i = 0; i < NC; i++) begin
      t_addr[i] = '0; t_data[i] = 32'h0; t_en[i] = 1'b0;
    end
    pack_table();
    repeat (2) @(negedge clk);
    chk("reset:cpu_rst", 32'(cpu_rst), 32'h1);
    chk("reset:others", {24'h0, cpu_run, busy, done, pass, halted, 3'b0}, 32'h0);
    chk("reset:results", {fail_mask, 4'(fail_count), 8'(cycles_run), 8'(rf_raddr)}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: x3..x6 hold 1..4, four enabled matching entries
    for (int i = 0; i < 4; i++) begin
      regs[3 + i] = 32'(i + 1);
      t_addr[i]   = AW'(3 + i);
      t_data[i]   = 32'(i + 1);
      t_en[i]     = 1'b1;
    end
    run_test("base", 1'b0);
    chk("base:mask_lit", 32'(fail_mask), 32'h0);

    t_data[2] = 32'd7;
    run_test("x5_bad", 1'b0);
    chk("x5_bad:mask_lit", 32'(fail_mask), 32'h0000_0004);

    t_en[2] = 1'b0;
    run_test("x5_skip", 1'b0);

    t_en[2] = 1'b1;
    t_data[2] = 32'd3;
    freeze = 6;
    run_test("halt6", 1'b0);
    chk("halt6:cycles_lit", 32'(cycles_run), 32'd10);

    random_table();
    freeze = $urandom_range(0, CB);
    run_test("disturb", 1'b1);

    for (int t = 0; t < 8; t++) begin
      random_table();
      freeze = (t == 0) ? CB - HC : $urandom_range(0, CB);
      run_test("rand", bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in RUN cycle 7, then a clean test
    random_table();
    freeze = 0;
    pack_table();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_run = 0;
    for (int c = 0; c < 100 && n_run < 7; c++) begin
      if (cpu_run) n_run++;
      if (n_run < 7) @(negedge clk);
    end
    chk("areset:reached", 32'(n_run), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("areset:cpu_rst", 32'(cpu_rst), 32'h1);
    chk("areset:cpu_run", 32'(cpu_run), 32'h0);
    chk("areset:busy", 32'(busy), 32'h0);
    chk("areset:cycles", 32'(cycles_run), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
